// File: rtl/bb_oth_uart_pkg.sv
// Shared constants for the bb_oth_uart memory-mapped 8N1 serial port:
// register offsets, STATUS bit positions and the bit-level FSM encoding.
package bb_oth_uart_pkg;

  localparam logic [1:0] UART_REG_TXDATA  = 2'd0;
  localparam logic [1:0] UART_REG_RXDATA  = 2'd1;
  localparam logic [1:0] UART_REG_STATUS  = 2'd2;
  localparam logic [1:0] UART_REG_BAUDDIV = 2'd3;

  localparam int ST_TXFULL         = 0;
  localparam int ST_TXEMPTY        = 1;
  localparam int ST_RXEMPTY        = 2;
  localparam int ST_RXFULL         = 3;
  localparam int ST_TXOVF          = 4;
  localparam int ST_RXOVF          = 5;
  localparam int ST_FRAMEERR       = 6;
  localparam int ST_TXBUSY         = 7;
  localparam int ST_IRQ_EN_RX      = 8;
  localparam int ST_IRQ_EN_TXEMPTY = 9;
  localparam int ST_LOOPBACK       = 10;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/bb_oth_uart_sync_fifo.sv
// bb_sync_fifo: synchronous FIFO with a combinational head. Push into a full
// FIFO is honoured only when a pop happens in the same cycle.
module bb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/bb_oth_uart.sv
// bb_oth_uart: 8N1 UART behind the core's oth_* bus with TX/RX FIFOs, STATUS
// and a level interrupt. Define BB_UART_LOOPBACK_EN for the STATUS[10] loopback.
module bb_oth_uart
  import bb_oth_uart_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 16'hFF00,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [15:0]           DIV_RESET  = 16'd217
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_oth_oen,
  input  logic                  i_oth_ien,
  input  logic [DATA_WIDTH-1:0] i_oth_addr,
  input  logic [DATA_WIDTH-1:0] i_oth_data,
  output logic [DATA_WIDTH-1:0] o_oth_data,
  output logic                  o_txd,
  input  logic                  i_rxd,
  output logic                  o_irq
);

  logic        hit, wr, rd, st_wr;
  logic [1:0]  off;
  logic [15:0] baud_div;
  logic        baud_restart;
  logic        tx_ovf, rx_ovf, frame_err;
  logic        irq_en_rx, irq_en_txempty, loopback;
  logic [15:0] status, rd_word;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_rdata;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_rdata;

  // A read that collides with a write is suppressed so it neither pops nor returns data.
  assign hit   = (i_oth_addr[DATA_WIDTH-1:2] == BASE_ADDR[DATA_WIDTH-1:2]);
  assign off   = i_oth_addr[1:0];
  assign wr    = i_oth_ien & hit;
  assign rd    = i_oth_oen & ~i_oth_ien & hit;
  assign st_wr = wr & (off == UART_REG_STATUS);

  assign tx_push = wr & (off == UART_REG_TXDATA);
  assign rx_pop  = rd & (off == UART_REG_RXDATA) & ~rx_empty;

  bb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
    .wdata(i_oth_data[7:0]), .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- TX bit engine ----------------
  uart_state_e tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_tick, txd_d, txd_q, tx_busy;

  assign tx_tick = (tx_cnt == 16'd0);
  assign tx_busy = (tx_state != UART_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= UART_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      UART_IDLE:  if (!tx_empty) tx_next = UART_START;
      UART_START: if (tx_tick) tx_next = UART_DATA;
      UART_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = UART_STOP;
      UART_STOP:  if (tx_tick) tx_next = tx_empty ? UART_IDLE : UART_START;
      default:    tx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    tx_pop = 1'b0;
    txd_d  = 1'b1;
    case (tx_state)
      UART_IDLE:  tx_pop = ~tx_empty;
      UART_START: txd_d  = 1'b0;
      UART_DATA:  txd_d  = tx_shift[0];
      UART_STOP:  tx_pop = tx_tick & ~tx_empty;
      default:    ;
    endcase
  end

  // The counter sits at the full divider in IDLE so every state lasts BAUDDIV+1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt   <= DIV_RESET;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      txd_q    <= 1'b1;
    end else begin
      txd_q <= txd_d;
      if (baud_restart || tx_state == UART_IDLE || tx_tick) tx_cnt <= baud_div;
      else                                                  tx_cnt <= tx_cnt - 16'd1;
      if (tx_pop) begin
        tx_shift <= tx_rdata;
      end else if (tx_state == UART_DATA && tx_tick) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  assign o_txd = txd_q | loopback;

  // ---------------- RX bit engine ----------------
  uart_state_e rx_state, rx_next;
  logic        rx_s1, rx_s2, rx_prev, rx_fall, rx_tick, rx_ferr_set;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_cnt == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= loopback ? txd_q : i_rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= UART_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      UART_IDLE:  if (rx_fall) rx_next = UART_START;
      UART_START: if (rx_tick) rx_next = rx_s2 ? UART_IDLE : UART_DATA;
      UART_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = UART_STOP;
      UART_STOP:  if (rx_tick) rx_next = UART_IDLE;
      default:    rx_next = UART_IDLE;
    endcase
  end

  always_comb begin
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    if (rx_state == UART_STOP && rx_tick) begin
      rx_push     = rx_s2;
      rx_ferr_set = ~rx_s2;
    end
  end

  // Idle holds half a bit so the first sample lands mid start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt   <= DIV_RESET >> 1;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
    end else begin
      if (baud_restart)                rx_cnt <= baud_div;
      else if (rx_state == UART_IDLE)  rx_cnt <= baud_div >> 1;
      else if (rx_tick)                rx_cnt <= baud_div;
      else                             rx_cnt <= rx_cnt - 16'd1;
      if (rx_state == UART_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  bb_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
    .wdata(rx_shift), .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );

  // ---------------- Registers, status, interrupt ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_div       <= DIV_RESET;
      baud_restart   <= 1'b0;
      tx_ovf         <= 1'b0;
      rx_ovf         <= 1'b0;
      frame_err      <= 1'b0;
      irq_en_rx      <= 1'b0;
      irq_en_txempty <= 1'b0;
      o_irq          <= 1'b0;
    end else begin
      baud_restart <= wr & (off == UART_REG_BAUDDIV);
      if (wr && off == UART_REG_BAUDDIV) baud_div <= i_oth_data[15:0];
      if (st_wr) begin
        irq_en_rx      <= i_oth_data[ST_IRQ_EN_RX];
        irq_en_txempty <= i_oth_data[ST_IRQ_EN_TXEMPTY];
      end
      // New events win over a same-cycle clear so none is lost.
      tx_ovf    <= (tx_ovf & ~(st_wr & i_oth_data[ST_TXOVF])) | (tx_push & tx_full & ~tx_pop);
      rx_ovf    <= (rx_ovf & ~(st_wr & i_oth_data[ST_RXOVF])) | (rx_push & rx_full & ~rx_pop);
      frame_err <= (frame_err & ~(st_wr & i_oth_data[ST_FRAMEERR])) | rx_ferr_set;
      o_irq     <= (irq_en_rx & ~rx_empty) | (irq_en_txempty & tx_empty & ~tx_busy);
    end
  end

`ifdef BB_UART_LOOPBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        loopback <= 1'b0;
    else if (st_wr) loopback <= i_oth_data[ST_LOOPBACK];
  end
`else
  assign loopback = 1'b0;
`endif

  always_comb begin
    status                    = '0;
    status[ST_TXFULL]         = tx_full;
    status[ST_TXEMPTY]        = tx_empty;
    status[ST_RXEMPTY]        = rx_empty;
    status[ST_RXFULL]         = rx_full;
    status[ST_TXOVF]          = tx_ovf;
    status[ST_RXOVF]          = rx_ovf;
    status[ST_FRAMEERR]       = frame_err;
    status[ST_TXBUSY]         = tx_busy;
    status[ST_IRQ_EN_RX]      = irq_en_rx;
    status[ST_IRQ_EN_TXEMPTY] = irq_en_txempty;
    status[ST_LOOPBACK]       = loopback;
  end

  always_comb begin
    rd_word = '0;
    if (rd) begin
      case (off)
        UART_REG_RXDATA:  if (!rx_empty) rd_word[7:0] = rx_rdata;
        UART_REG_STATUS:  rd_word = status;
        UART_REG_BAUDDIV: rd_word = baud_div;
        default:          ;
      endcase
    end
  end

  assign o_oth_data = DATA_WIDTH'(rd_word);

endmodule

// File: tb/tb_bb_oth_uart.sv
// Self-checking bench for bb_oth_uart: register vector table, hand sequences
// for frame timing/reset/interrupt, and randomized TX/RX against queue models.
`timescale 1ns/1ps
module tb_bb_oth_uart;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 4;
  localparam logic [15:0] S_TXFULL   = 16'h0001;
  localparam logic [15:0] S_TXEMPTY  = 16'h0002;
  localparam logic [15:0] S_RXEMPTY  = 16'h0004;
  localparam logic [15:0] S_RXFULL   = 16'h0008;
  localparam logic [15:0] S_TXOVF    = 16'h0010;
  localparam logic [15:0] S_RXOVF    = 16'h0020;
  localparam logic [15:0] S_FRAMEERR = 16'h0040;
  localparam logic [15:0] S_TXBUSY   = 16'h0080;
`ifdef BB_UART_LOOPBACK_EN
  localparam logic [15:0] LB_MASK = 16'h0400;
`else
  localparam logic [15:0] LB_MASK = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        oen, ien, txd, rxd, irq;
  logic [15:0] addr, wdata, rdata;

  always #5 clk = ~clk;

  bb_oth_uart #(
    .DATA_WIDTH(16), .BASE_ADDR(16'hFF00), .FIFO_DEPTH(4), .DIV_RESET(16'd217)
  ) dut (
    .clk(clk), .rst(rst), .i_oth_oen(oen), .i_oth_ien(ien), .i_oth_addr(addr),
    .i_oth_data(wdata), .o_oth_data(rdata), .o_txd(txd), .i_rxd(rxd), .o_irq(irq)
  );

  int checks   = 0;
  int failures = 0;
  logic irq_at_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    ien = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    ien = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    oen = 1'b1; addr = a;
    #1;
    d = rdata;
    irq_at_rd = irq;
    @(negedge clk);
    oen = 1'b0;
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [15:0] d);
    bus_write(BASE | 16'(off), d);
  endtask

  task automatic reg_read(input logic [1:0] off, output logic [15:0] d);
    bus_read(BASE | 16'(off), d);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int p);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = f[i];
      repeat (p - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_idle(input string name, input int max_reads);
    logic [15:0] s;
    int n;
    n = 0;
    do begin
      reg_read(2'd2, s);
      n++;
    end while ((((s & S_TXBUSY) != 0) || ((s & S_TXEMPTY) == 0)) && n < max_reads);
    check({name, "_tx_idle"}, s & (S_TXBUSY | S_TXEMPTY), S_TXEMPTY);
  endtask

  // ---------------- TX line monitor and scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] tx_got_q[$];
  bit         mon_en  = 1'b0;
  int         mon_p   = 4;
  int         mon_bad = 0;

  initial begin : tx_monitor
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        repeat (mon_p / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_p) @(negedge clk);
          b[i] = txd;
        end
        repeat (mon_p) @(negedge clk);
        if (txd !== 1'b1) mon_bad++;
        tx_got_q.push_back(b);
      end
    end
  end

  task automatic compare_tx(input string name);
    check({name, "_count"}, tx_got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && tx_got_q.size() > 0)
      check({name, "_byte"}, tx_got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    tx_got_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vt[13];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] s, d;
    logic [9:0]  frame;
    logic [3:0]  grp;
    int          n, p, cnt, low_seen;
    bit          ovf;

    vt[0]  = '{1'b0, BASE | 16'd2, 16'h0000, 16'h0006, "rst_status"};
    vt[1]  = '{1'b0, BASE | 16'd3, 16'h0000, 16'h00D9, "rst_bauddiv"};
    vt[2]  = '{1'b0, BASE | 16'd0, 16'h0000, 16'h0000, "txdata_reads_zero"};
    vt[3]  = '{1'b0, BASE | 16'd1, 16'h0000, 16'h0000, "rxdata_empty_zero"};
    vt[4]  = '{1'b1, BASE | 16'd3, 16'h1234, 16'h0000, "wr_baud"};
    vt[5]  = '{1'b0, BASE | 16'd3, 16'h0000, 16'h1234, "baud_rw"};
    vt[6]  = '{1'b1, BASE | 16'd2, 16'h07F0, 16'h0000, "wr_status"};
    vt[7]  = '{1'b0, BASE | 16'd2, 16'h0000, 16'h0306 | LB_MASK, "status_en_bits"};
    vt[8]  = '{1'b1, BASE | 16'd2, 16'h0000, 16'h0000, "wr_status0"};
    vt[9]  = '{1'b0, BASE | 16'd2, 16'h0000, 16'h0006, "status_cleared"};
    vt[10] = '{1'b0, 16'hFF04,     16'h0000, 16'h0000, "miss_above"};
    vt[11] = '{1'b0, 16'h0002,     16'h0000, 16'h0000, "miss_low"};
    vt[12] = '{1'b0, 16'hFE03,     16'h0000, 16'h0000, "miss_below"};

    rst = 1'b1; oen = 1'b0; ien = 1'b0; addr = '0; wdata = '0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Register table
    for (int i = 0; i < 13; i++) begin
      if (vt[i].is_wr) bus_write(vt[i].a, vt[i].d);
      else begin
        bus_read(vt[i].a, d);
        check(vt[i].name, d, vt[i].exp);
      end
    end

    // Simultaneous strobes: write wins, read data is zero
    oen = 1'b1; ien = 1'b1; addr = BASE | 16'd3; wdata = 16'd5;
    #1 check("simul_read_zero", rdata, 16'h0000);
    @(negedge clk);
    oen = 1'b0; ien = 1'b0;
    reg_read(2'd3, d);
    check("simul_write_done", d, 16'd5);

    // TX-empty interrupt: registered, one cycle late
    reg_write(2'd2, 16'h0200);
    check("irq_txe_lag", irq, 1'b0);
    @(negedge clk);
    check("irq_txe_set", irq, 1'b1);
    reg_write(2'd2, 16'h0000);
    @(negedge clk);
    check("irq_txe_clr", irq, 1'b0);

    // Reset in the middle of a frame
    reg_write(2'd3, 16'd3);
    reg_write(2'd0, 16'h0000);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("rst_frame_started", n < 50, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_txd_async", txd, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    reg_read(2'd2, d);
    check("rst_mid_status", d, 16'h0006);
    reg_read(2'd3, d);
    check("rst_mid_baud", d, 16'd217);

    // Single TX frame, 4 cycles per bit
    reg_write(2'd3, 16'd3);
    reg_write(2'd0, 16'h00A5);
    n = 0;
    while (txd !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("tx_a5_start_seen", n < 50, 1'b1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 4; k++) begin
        grp[k] = txd;
        @(negedge clk);
      end
      check($sformatf("tx_a5_bit%0d", b), grp, {4{frame[b]}});
    end
    check("tx_a5_idle_high", txd, 1'b1);
    reg_read(2'd2, d);
    check("tx_a5_busy_fell", d & S_TXBUSY, 16'h0000);

    // TX overflow: shifter + 4 FIFO entries accept 5 of 6 back-to-back writes
    mon_p = 4; mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom_range(0, 255));
      if (i < DEPTH + 1) exp_q.push_back(d[7:0]);
      reg_write(2'd0, d);
    end
    reg_read(2'd2, s);
    check("txovf_flags", s & (S_TXFULL | S_TXOVF), S_TXFULL | S_TXOVF);
    reg_write(2'd2, 16'h0010);
    reg_read(2'd2, s);
    check("txovf_cleared", s & S_TXOVF, 16'h0000);
    wait_tx_idle("txovf", 400);
    repeat (2 * mon_p) @(negedge clk);
    compare_tx("txovf");

    // Randomized TX bursts at random dividers
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(1, 5);
      reg_write(2'd3, 16'(p));
      mon_p = p + 1;
      cnt = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < cnt; i++) begin
        d = 16'($urandom_range(0, 255));
        exp_q.push_back(d[7:0]);
        reg_write(2'd0, d);
      end
      wait_tx_idle($sformatf("txrand%0d", r), 600);
      repeat (2 * mon_p) @(negedge clk);
      compare_tx($sformatf("txrand%0d", r));
    end
    reg_read(2'd2, s);
    check("txrand_no_ovf", s & S_TXOVF, 16'h0000);
    check("tx_stop_bits", mon_bad, 0);
    mon_en = 1'b0;

    // RX single byte at BAUDDIV=7
    reg_write(2'd3, 16'd7);
    send_rx(8'h3C, 1'b1, 8);
    repeat (2) @(negedge clk);
    reg_read(2'd2, s);
    check("rx_not_empty", s & S_RXEMPTY, 16'h0000);
    reg_read(2'd1, d);
    check("rx_3c", d, 16'h003C);
    reg_read(2'd2, s);
    check("rx_empty_after_pop", s & (S_RXEMPTY | S_FRAMEERR), S_RXEMPTY);

    // Bad stop bit
    send_rx(8'($urandom_range(0, 255)), 1'b0, 8);
    repeat (4) @(negedge clk);
    reg_read(2'd2, s);
    check("rx_frameerr", s & (S_RXEMPTY | S_FRAMEERR), S_RXEMPTY | S_FRAMEERR);
    reg_write(2'd2, 16'h0040);
    reg_read(2'd2, s);
    check("rx_frameerr_clr", s & S_FRAMEERR, 16'h0000);

    // Two-cycle glitch is a false start
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (120) @(negedge clk);
    reg_read(2'd2, s);
    check("rx_glitch", s & (S_RXEMPTY | S_FRAMEERR), S_RXEMPTY);

    // RX interrupt timing
    reg_write(2'd2, 16'h0100);
    @(negedge clk);
    check("irq_rx_idle", irq, 1'b0);
    fork
      send_rx(8'h81, 1'b1, 8);
    join_none
    n = 0;
    do begin
      reg_read(2'd2, s);
      n++;
    end while ((s & S_RXEMPTY) != 0 && n < 200);
    check("irq_rx_byte_seen", s & S_RXEMPTY, 16'h0000);
    check("irq_rx_lag", irq_at_rd, 1'b0);
    check("irq_rx_rise", irq, 1'b1);
    repeat (20) @(negedge clk);
    reg_read(2'd1, d);
    check("irq_rx_data", d, 16'h0081);
    check("irq_hold_in_read", irq, 1'b1);
    @(negedge clk);
    check("irq_rx_fall", irq, 1'b0);
    reg_write(2'd2, 16'h0000);

    // Randomized RX against a bounded-queue model, including overflow
    for (int r = 0; r < 4; r++) begin
      p = $urandom_range(5, 15);
      reg_write(2'd3, 16'(p));
      cnt = (r == 0) ? DEPTH + 1 : $urandom_range(1, DEPTH + 2);
      ovf = 1'b0;
      for (int i = 0; i < cnt; i++) begin
        d = 16'($urandom_range(0, 255));
        if (exp_q.size() < DEPTH) exp_q.push_back(d[7:0]);
        else                      ovf = 1'b1;
        send_rx(d[7:0], 1'b1, p + 1);
        repeat (2) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      reg_read(2'd2, s);
      check($sformatf("rxrand%0d_ovf", r), s & (S_RXOVF | S_RXFULL),
            (ovf ? S_RXOVF : 16'h0000) | ((exp_q.size() == DEPTH) ? S_RXFULL : 16'h0000));
      while (exp_q.size() > 0) begin
        reg_read(2'd1, d);
        check($sformatf("rxrand%0d_byte", r), d, {8'h00, exp_q.pop_front()});
      end
      reg_read(2'd1, d);
      check($sformatf("rxrand%0d_drained", r), d, 16'h0000);
      reg_write(2'd2, 16'h0020);
    end

`ifdef BB_UART_LOOPBACK_EN
    // Loopback: TX feeds RX internally while the pin idles high
    reg_write(2'd3, 16'd7);
    reg_write(2'd2, 16'h0400);
    reg_write(2'd0, 16'h005A);
    low_seen = 0;
    repeat (140) begin
      @(negedge clk);
      if (txd !== 1'b1) low_seen++;
    end
    check("lb_txd_high", low_seen, 0);
    reg_read(2'd1, d);
    check("lb_rx_5a", d, 16'h005A);
    reg_write(2'd2, 16'h0000);
`else
    low_seen = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bb_oth_uart.md
Name: bb_oth_uart

Overview:
- Memory-mapped 8N1 serial port on the core's "other device" port, downstream of the core's oth_* bus.
- The core writes bytes into a TX FIFO and reads received bytes from an RX FIFO through four word registers.
- TX and RX are serialised and deserialised by two independent bit-level state machines.
- A status register and a level interrupt let firmware poll or wait for events.

Parameters:
- DATA_WIDTH, 16, bus word width; must be >= 16.
- BASE_ADDR, 16'hFF00, base of the 4-word register window; address bits [1:0] select the register.
- FIFO_DEPTH, 4, entries per FIFO; power of two, 2..16.
- DIV_RESET, 16'd217, reset value of the baud divider (clock cycles per bit, minus 1).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- i_oth_oen  in  1  core read strobe, one cycle per access.
- i_oth_ien  in  1  core write strobe, one cycle per access.
- i_oth_addr  in  DATA_WIDTH  access address.
- i_oth_data  in  DATA_WIDTH  write data.
- o_oth_data  out  DATA_WIDTH  read data; combinational; all-zero unless a read hits the window.
- o_txd  out  1  serial output; idles high.
- i_rxd  in  1  serial input; asynchronous to clk.
- o_irq  out  1  level interrupt, registered.

Behaviour:
- Hit condition: i_oth_addr[DATA_WIDTH-1:2] == BASE_ADDR[DATA_WIDTH-1:2].
- Register offset 0, TXDATA:
  - Write of bits [7:0] pushes the TX FIFO.
  - A push while the TX FIFO is full is dropped and sets sticky STATUS.txovf.
  - Reads return 0.
- Register offset 1, RXDATA:
  - Read returns the RX FIFO head in bits [7:0], upper bits 0.
  - The pop takes effect at the clock edge ending the read cycle.
  - Reading while the RX FIFO is empty returns 0 and changes nothing.
- Register offset 2, STATUS (read), with bit layout:
  - [0] txfull, [1] txempty, [2] rxempty, [3] rxfull.
  - [4] txovf, [5] rxovf, [6] frameerr (sticky bits).
  - [7] txbusy, [8] irq_en_rx, [9] irq_en_txempty.
- STATUS write:
  - Writing 1 to bits [6:4] clears those sticky flags.
  - Bits [9:8] are written directly.
- Register offset 3, BAUDDIV:
  - Read/write, full 16 bits.
  - A write restarts both baud counters on the next cycle.
  - Any frame in flight keeps its current bit index.
- Reset values:
  - o_txd=1, o_irq=0, both FIFOs empty, all sticky flags 0, irq enables 0.
  - BAUDDIV=DIV_RESET, both FSMs IDLE.
  - Reset mid-frame aborts the frame immediately; o_txd returns high asynchronously.
- Simultaneous strobes: if i_oth_oen and i_oth_ien are both high in one cycle, the write is performed and the read returns 0.
- TX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - Leaves IDLE on the cycle after a non-empty FIFO is seen, popping one byte.
  - Each state holds for BAUDDIV+1 cycles.
  - DATA sends bits LSB-first, 8 bits, counted by a 3-bit counter.
  - From STOP, moves directly to START if the FIFO is non-empty (back-to-back frames, no idle bit).
  - txbusy = FSM not in IDLE.
- RX input path: i_rxd passes through a 2-flop synchroniser, reset value 1.
- RX FSM, IDLE -> START -> DATA -> STOP -> IDLE:
  - A falling edge in IDLE enters START and loads the counter with BAUDDIV>>1.
  - At half-bit, if the sampled line is high, the start is false and the FSM returns to IDLE.
  - DATA samples 8 bits at full-bit intervals.
  - In STOP, a sample of 0 sets frameerr and discards the byte.
  - A sample of 1 pushes the byte.
  - A push while the RX FIFO is full drops the byte and sets rxovf.
- FIFOs:
  - Same-cycle push and pop are both honoured, including when full (on pop) or empty (on push, no bypass).
  - Pointers wrap modulo FIFO_DEPTH.
  - The count is log2(FIFO_DEPTH)+1 bits wide.
- Interrupt: o_irq is registered as (irq_en_rx & ~rxempty) | (irq_en_txempty & txempty & ~txbusy); one cycle of latency.

Optional Feature:
- BB_UART_LOOPBACK_EN defined:
  - STATUS bit [10] is read/write loopback, reset 0.
  - When it is set, the RX synchroniser input is taken from internal o_txd instead of i_rxd.
  - o_txd is held high externally.
- Not defined: bit [10] reads 0 and writes to it are ignored; the RX path always uses i_rxd.

Decomposition:
- define.v gains:
  - UART_REG_TXDATA/RXDATA/STATUS/BAUDDIV offsets (0..3).
  - STATUS bit-index constants.
  - FSM state encodings UART_IDLE/START/DATA/STOP as 2-bit values.
- One sub-module, bb_sync_fifo: parameterised width/depth, ports push, pop, wdata, rdata (head, combinational), full, empty.
- Instantiated twice, 8 bits wide.

Test Plan:
- Reset:
  - Stimulus: assert rst mid-TX frame.
  - Required: o_txd=1 at once; STATUS reads 16'h0006; BAUDDIV reads 217.
- Single TX:
  - Stimulus: BAUDDIV=3, write TXDATA=8'hA5.
  - Required: o_txd shows start 0 then bits 1,0,1,0,0,1,0,1, then stop 1, each bit 4 cycles; 40 cycles total; txbusy falls afterwards.
- TX overflow:
  - Stimulus: 6 back-to-back TXDATA writes with FIFO_DEPTH=4 and a busy shifter.
  - Required: 5 bytes accepted (one already in the shifter), 1 dropped, txovf=1.
  - Then write STATUS=16'h0010: txovf reads 0.
- RX:
  - Stimulus: drive i_rxd with byte 8'h3C at BAUDDIV=7.
  - Required: rxempty falls; RXDATA reads 16'h003C; rxempty rises on the next cycle.
  - Stop bit driven 0: frameerr=1 and the FIFO stays empty.
- Glitch and interrupt:
  - Stimulus: 2-cycle low pulse on i_rxd at BAUDDIV=7.
  - Required: no byte received.
  - With irq_en_rx=1, a valid byte raises o_irq one cycle after rxempty falls; it drops one cycle after the RXDATA read.
- Loopback (macro defined):
  - Stimulus: set bit [10], write TXDATA=8'h5A.
  - Required: RXDATA later reads 16'h005A; external o_txd stays 1 throughout.
